// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder step per clock, LSB first, WIDTH cycles per add.
// Result registered on entry to DONE; done pulses once there, then back to IDLE.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-2:0] psum_q, psum_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  logic             bit_s;
  logic             bit_c;
  logic [WIDTH-1:0] shifted;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      psum_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      psum_q  <= psum_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    psum_d  = psum_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;

    bit_s   = a_q[0] ^ b_q[0] ^ carry_q;
    bit_c   = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
    // Partial sum keeps WIDTH-1 bits; the final step's bit completes the word.
    shifted = {bit_s, psum_q};

    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          psum_d  = '0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        psum_d  = shifted[WIDTH-1:1];
        carry_d = bit_c;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          sum_d   = shifted;
          cout_d  = bit_c;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Randomised and directed bench for serial_adder at WIDTH=8, plus an exhaustive WIDTH=2 instance.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;

  logic         start = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         cin = 1'b0;
  logic         busy, done, cout;
  logic [W-1:0] sum;

  logic         start2 = 1'b0;
  logic [1:0]   a2 = '0, b2 = '0;
  logic         cin2 = 1'b0;
  logic         busy2, done2, cout2;
  logic [1:0]   sum2;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  serial_adder #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .cin(cin2),
    .busy(busy2), .done(done2), .sum(sum2), .cout(cout2)
  );

  // Reference: {cout,sum} is plain integer addition of the three operands.
  function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
  endfunction

  // One full operation; the accepting edge is E0, the result is visible after edge E(W).
  task automatic run_op(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc);
    logic [W:0]   exp;
    logic [W-1:0] prev_sum;
    logic         prev_cout;
    exp       = ref_add(xa, xb, xc);
    prev_sum  = sum;
    prev_cout = cout;
    @(negedge clk);
    a = xa; b = xb; cin = xc; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    for (int i = 0; i <= W; i++) begin
      if (i > 0) begin
        @(posedge clk); #1;
      end
      n_cmp++;
      if (busy !== 1'b1) begin
        n_err++; $display("FAIL op_busy cycle %0d: got %b want 1", i, busy);
      end
      if (i < W) begin
        n_cmp++;
        if (done !== 1'b0 || sum !== prev_sum || cout !== prev_cout) begin
          n_err++;
          $display("FAIL op_hold cycle %0d: done=%b sum=%h cout=%b want done=0 sum=%h cout=%b",
                   i, done, sum, cout, prev_sum, prev_cout);
        end
      end else begin
        n_cmp++;
        if (done !== 1'b1 || {cout, sum} !== exp) begin
          n_err++;
          $display("FAIL op_result %h+%h+%b: done=%b {cout,sum}=%h want done=1 %h",
                   xa, xb, xc, done, {cout, sum}, exp);
        end
      end
    end
    @(posedge clk); #1;
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL op_return_idle: done=%b busy=%b want 0 0", done, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    start = 1'b1; a = 8'hAA; b = 8'h55; cin = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || sum !== '0 || cout !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: busy=%b done=%b sum=%h cout=%b want all 0", busy, done, sum, cout);
    end
    n_cmp++;
    if (busy2 !== 1'b0 || done2 !== 1'b0 || sum2 !== 2'b0 || cout2 !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state_w2: busy=%b done=%b sum=%h cout=%b want all 0", busy2, done2, sum2, cout2);
    end
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++; $display("FAIL reset_release_idle: busy=%b want 0", busy);
    end
  endtask

  task automatic test_directed();
    run_op(8'h00, 8'h00, 1'b0);
    run_op(8'hFF, 8'h01, 1'b0);
    run_op(8'hFF, 8'hFF, 1'b1);
    run_op(8'h80, 8'h80, 1'b0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 20; k++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom));
    end
  endtask

  task automatic test_exhaustive_w2();
    logic [2:0] exp;
    for (int xa = 0; xa < 4; xa++) begin
      for (int xb = 0; xb < 4; xb++) begin
        for (int xc = 0; xc < 2; xc++) begin
          exp = 3'(xa + xb + xc);
          @(negedge clk);
          a2 = 2'(xa); b2 = 2'(xb); cin2 = 1'(xc); start2 = 1'b1;
          @(posedge clk); #1;
          start2 = 1'b0; a2 = ~a2; b2 = ~b2; cin2 = ~cin2;
          @(posedge clk); #1;
          n_cmp++;
          if (done2 !== 1'b0 || busy2 !== 1'b1) begin
            n_err++; $display("FAIL w2_shift %0d+%0d+%0d: done=%b busy=%b want 0 1", xa, xb, xc, done2, busy2);
          end
          @(posedge clk); #1;
          n_cmp++;
          if (done2 !== 1'b1 || {cout2, sum2} !== exp) begin
            n_err++;
            $display("FAIL w2_result %0d+%0d+%0d: done=%b {cout,sum}=%0d want done=1 %0d",
                     xa, xb, xc, done2, {cout2, sum2}, exp);
          end
          @(posedge clk); #1;
          n_cmp++;
          if (busy2 !== 1'b0) begin
            n_err++; $display("FAIL w2_idle: busy=%b want 0", busy2);
          end
        end
      end
    end
  endtask

  task automatic test_ignore_start();
    bit extra_done;
    @(negedge clk);
    a = 8'h3C; b = 8'h0F; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    a = 8'hF0; b = 8'hAA; cin = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (W - 2) @(posedge clk);
    #1;
    n_cmp++;
    if (done !== 1'b1 || sum !== 8'h4B || cout !== 1'b0) begin
      n_err++;
      $display("FAIL ignore_start_result: done=%b sum=%h cout=%b want 1 4b 0", done, sum, cout);
    end
    extra_done = 1'b0;
    repeat (2 * W) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) extra_done = 1'b1;
    end
    n_cmp++;
    if (extra_done !== 1'b0) begin
      n_err++; $display("FAIL ignore_start_no_restart: got activity=%b want 0", extra_done);
    end
  endtask

  task automatic test_reset_mid();
    bit spurious;
    run_op(8'h7E, 8'h55, 1'b1);
    @(negedge clk);
    a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || sum !== '0 || cout !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid_clear: busy=%b done=%b sum=%h cout=%b want all 0", busy, done, sum, cout);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    spurious = 1'b0;
    repeat (2 * W) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1 || sum !== '0) spurious = 1'b1;
    end
    n_cmp++;
    if (spurious !== 1'b0) begin
      n_err++; $display("FAIL reset_mid_no_done: got activity=%b want 0", spurious);
    end
    run_op(8'h10, 8'h20, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] ta [3];
    logic [W-1:0] tb [3];
    logic         tc [3];
    logic [W:0]   exp;
    int           n_done, last;
    for (int k = 0; k < 3; k++) begin
      ta[k] = W'($urandom); tb[k] = W'($urandom); tc[k] = 1'($urandom);
    end
    n_done = 0;
    last   = 0;
    @(negedge clk);
    a = ta[0]; b = tb[0]; cin = tc[0]; start = 1'b1;
    for (int cyc = 0; cyc < 4 * (W + 2); cyc++) begin
      @(posedge clk); #1;
      if (done === 1'b1 && n_done < 3) begin
        exp = ref_add(ta[n_done], tb[n_done], tc[n_done]);
        n_cmp++;
        if ({cout, sum} !== exp) begin
          n_err++; $display("FAIL b2b_result op %0d: got %h want %h", n_done, {cout, sum}, exp);
        end
        n_cmp++;
        if ((n_done == 0 && cyc != W) || (n_done > 0 && cyc - last != W + 2)) begin
          n_err++; $display("FAIL b2b_spacing op %0d: got cycle %0d (prev %0d) want spacing %0d", n_done, cyc, last, W + 2);
        end
        last = cyc;
        n_done++;
        if (n_done < 3) begin
          a = ta[n_done]; b = tb[n_done]; cin = tc[n_done];
        end else begin
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    n_cmp++;
    if (n_done != 3) begin
      n_err++; $display("FAIL b2b_timeout: got %0d done pulses want 3", n_done);
    end
    repeat (W + 4) @(posedge clk);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_exhaustive_w2();
    test_random();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
